// File: rtl/div32s_seq.sv
// Sequential 32-bit signed divider: radix-2 restoring core on magnitudes, one quotient bit per clock,
// with valid/ready handshakes on both the operand and result sides.
`timescale 1ns/1ps
module div32s_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quo,
   output logic [31:0] rem,
   output logic        dbz
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_r, state_nxt_s;
   logic [31:0] dvd_r, dvs_r, quo_r, rem_r;
   logic [32:0] prem_r;
   logic        neg_q_r, neg_r_r, dbz_r;
   logic [5:0]  cnt_r;

   logic        accept_s, zero_div_s, ovf_s, last_s, qbit_s;
   logic [32:0] trial_s, prem_nxt_s;
   logic [33:0] diff_s;
   logic [31:0] q_fin_s, mag1_s, mag2_s;

   // 32'h80000000 negates to itself, which read as unsigned is exactly 2^31.
   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

   assign mag1_s = mag(op1);
   assign mag2_s = mag(op2);

   // Handshake decode and one restoring-division step.
   always_comb begin
      accept_s   = in_valid && (state_r == IDLE);
      zero_div_s = (op2 == 32'd0);
      ovf_s      = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
      last_s     = (cnt_r == 6'd31);
      trial_s    = {prem_r[31:0], dvd_r[31]};
      diff_s     = {1'b0, trial_s} - {2'b00, dvs_r};
      // prem_r[32] is never set for in-range remainders; folding it in keeps the decision total.
      qbit_s     = prem_r[32] | ~diff_s[33];
      prem_nxt_s = qbit_s ? diff_s[32:0] : trial_s;
      q_fin_s    = {dvd_r[30:0], qbit_s};
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (zero_div_s || ovf_s) state_nxt_s = DONE;
               else                     state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (last_s) state_nxt_s = DONE;
            else        state_nxt_s = CALC;
         end
         DONE: begin
            if (out_ready) state_nxt_s = IDLE;
            else           state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Operand capture, iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_r   <= 32'd0;
         dvs_r   <= 32'd0;
         prem_r  <= 33'd0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         cnt_r   <= 6'd0;
         quo_r   <= 32'd0;
         rem_r   <= 32'd0;
         dbz_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  dvd_r   <= mag1_s;
                  dvs_r   <= mag2_s;
                  prem_r  <= 33'd0;
                  neg_q_r <= op1[31] ^ op2[31];
                  neg_r_r <= op1[31];
                  cnt_r   <= 6'd0;
                  if (zero_div_s) begin
                     quo_r <= 32'hFFFF_FFFF;
                     rem_r <= op1;
                     dbz_r <= 1'b1;
                  end else if (ovf_s) begin
                     quo_r <= 32'h8000_0000;
                     rem_r <= 32'd0;
                     dbz_r <= 1'b0;
                  end
               end
            end
            CALC: begin
               dvd_r  <= q_fin_s;
               prem_r <= prem_nxt_s;
               cnt_r  <= cnt_r + 6'd1;
               if (last_s) begin
                  quo_r <= neg_q_r ? (32'd0 - q_fin_s) : q_fin_s;
                  rem_r <= neg_r_r ? (32'd0 - prem_nxt_s[31:0]) : prem_nxt_s[31:0];
                  dbz_r <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign quo       = quo_r;
   assign rem       = rem_r;
   assign dbz       = dbz_r;
endmodule

// File: tb/tb_div32s_seq.sv
// Self-checking bench for div32s_seq: directed corner cases plus random operands against a
// plain signed-arithmetic reference model.
`timescale 1ns/1ps
module tb_div32s_seq;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready, dbz;
   logic [31:0] op1, op2, quo, rem;
   int          errors = 0;
   int          checks = 0;

   div32s_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
      .quo(quo), .rem(rem), .dbz(dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Signed division truncating toward zero, with the two defined special cases.
   task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r, output logic d);
      int sa, sb;
      sa = a;
      sb = b;
      d  = 1'b0;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; d = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0;
      end else begin
         q = sa / sb; r = sa % sb;
      end
   endtask

   // One full transaction: accept, latency, result, hold under back-pressure, output handshake.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall);
      logic [31:0] eq, er;
      logic        ed;
      int          lat, exp_lat;
      bit          busy_ok;
      ref_model(a, b, eq, er, ed);
      exp_lat = (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; op1 = a; op2 = b;
      @(posedge clk); #1;
      lat = 1;
      in_valid = 1'b1; op1 = $urandom; op2 = $urandom;
      busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (in_ready) busy_ok = 1'b0;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("busy_no_ready", {31'd0, busy_ok}, 32'd1);
      chk("quo", quo, eq);
      chk("rem", rem, er);
      chk("dbz", {31'd0, dbz}, {31'd0, ed});
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_quo", quo, eq);
         chk("hold_rem", rem, er);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
      chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h8000_0000;
         5:       return 32'($urandom_range(0, 255));
         6:       return 32'd0 - 32'($urandom_range(1, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op1 = 32'd0; op2 = 32'd0;
      #3;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quo", quo, 32'd0);
      chk("rst_rem", rem, 32'd0);
      chk("rst_dbz", {31'd0, dbz}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      run_op(32'd100, 32'd7, 0);
      run_op(32'hFFFF_FF9C, 32'd7, 0);
      run_op(32'd100, 32'hFFFF_FFF9, 0);
      run_op(32'd7, 32'd0, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(32'h8000_0000, 32'd3, 10);

      // Abort mid-calculation with an asynchronous reset.
      @(negedge clk);
      in_valid = 1'b1; op1 = 32'd1000; op2 = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_quo", quo, 32'd0);
      chk("abort_rem", rem, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd50, 32'd5, 0);

      for (int i = 0; i < 1500; i++) begin
         run_op(pick(), pick(), $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
